debounce_multi: RTL

Parametrised N-channel debouncer with per-channel edge pulses and optional long-press detection. It replaces the single-button debouncer wherever a board exposes several push-buttons or switches. It sits between the raw FPGA input pins and the control FSMs. It gives each channel a clean level plus single-cycle press/release strobes, so downstream logic no longer builds its own edge detectors.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/debounce_ch.sv | 146 ++++++++++++++
 rtl/debounce_multi.sv | 46 ++++
 3 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and default timing constants for the
//               multi-channel debouncer (state encoding, 100 MHz defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  // Per-channel debounce state; the debounced level is 1 in ST_HIGH/ST_FALL.
  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } db_state_t;

  // 2 ms acceptance window at 100 MHz.
  localparam int unsigned C_DEFAULT_THRESH      = 200_000;
  // 0.5 s long-press window at 100 MHz.
  localparam int unsigned C_DEFAULT_HOLD_THRESH = 50_000_000;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : debounce_ch
// Description : One debounce channel: two-flop synchroniser, four-state
//               acceptance FSM with stability counter, registered level and
//               press/release strobes, optional long-press strobe.
//               Long-press logic is built only when DEBOUNCE_LONG_PRESS_EN
//               is defined; otherwise long_press is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 18,
  parameter int unsigned THRESH      = C_DEFAULT_THRESH,
  parameter int unsigned HOLD_WIDTH  = 26,
  parameter int unsigned HOLD_THRESH = C_DEFAULT_HOLD_THRESH
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic db_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic long_press
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(THRESH - 1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);

  logic                 r_s0;
  logic                 r_s1;
  db_state_t            r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_db;
  logic                 r_rise;
  logic                 r_fall;
  logic                 w_level;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= btn;
      r_s1 <= r_s0;
    end
  end

  // Accepted level as implied by the current state.
  assign w_level = (r_state == ST_HIGH) || (r_state == ST_FALL);

  // Acceptance FSM plus registered level and edge strobes derived from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_db   <= w_level;
      r_rise <= w_level & ~r_db;
      r_fall <= ~w_level & r_db;
      case (r_state)
        ST_LOW: begin
          if (r_s1) begin
            r_state <= ST_RISE;
            r_cnt   <= C_CNT_ONE;
          end else begin
            r_cnt <= '0;
          end
        end
        ST_RISE: begin
          if (!r_s1) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == C_CNT_LAST) begin
            r_state <= ST_HIGH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HIGH: begin
          if (!r_s1) begin
            r_state <= ST_FALL;
            r_cnt   <= C_CNT_ONE;
          end else begin
            r_cnt <= '0;
          end
        end
        ST_FALL: begin
          if (r_s1) begin
            r_state <= ST_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == C_CNT_LAST) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign db_out     = r_db;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam logic [HOLD_WIDTH-1:0] C_HOLD_LAST = HOLD_WIDTH'(HOLD_THRESH - 1);
  localparam logic [HOLD_WIDTH-1:0] C_HOLD_MAX  = HOLD_WIDTH'(HOLD_THRESH);

  logic [HOLD_WIDTH-1:0] r_hold;
  logic                  r_long;

  // Count cycles of accepted high; strobe once on reaching the threshold,
  // then park at the threshold until release re-arms the counter.
  always_ff @(posedge clk) begin
    if (rst || !r_db) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= (r_hold == C_HOLD_LAST);
      if (r_hold != C_HOLD_MAX) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  assign long_press = r_long;
`else
  // Feature not built; the hold parameters only appear here so the
  // parameter list stays identical across both builds.
  assign long_press = 1'b0 && (HOLD_WIDTH > 0) && (HOLD_THRESH > 0);
`endif

endmodule : debounce_ch
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : debounce_multi
// Description : N independent debounce channels, each giving a clean level
//               and single-cycle press/release strobes. Long-press strobes
//               are available when DEBOUNCE_LONG_PRESS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_WIDTH   = 18,
  parameter int unsigned THRESH      = C_DEFAULT_THRESH,
  parameter int unsigned HOLD_WIDTH  = 26,
  parameter int unsigned HOLD_THRESH = C_DEFAULT_HOLD_THRESH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] long_press
);

  // One fully independent channel per input bit.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_WIDTH  (CNT_WIDTH),
      .THRESH     (THRESH),
      .HOLD_WIDTH (HOLD_WIDTH),
      .HOLD_THRESH(HOLD_THRESH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn       (btn[i]),
      .db_out    (db_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i]),
      .long_press(long_press[i])
    );
  end

endmodule : debounce_multi
`default_nettype wire
